// File: rtl/frame_pkg.sv
// Shared constants and FSM encodings for the double-buffered OLED frame store.
package frame_pkg;

   localparam int WIDTH        = 96;
   localparam int HEIGHT       = 64;
   localparam int FRAME_PIXELS = WIDTH * HEIGHT;
   localparam int IDX_W        = 14;
   localparam int ADDR_W       = 13;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t WRITE = 2'd1;
   localparam state_t HOLD  = 2'd2;

endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: simple dual-port RAM, single write port, registered read port.
module frame_bank_ram #(
   parameter int               DEPTH          = 6144,
   parameter int               ADDR_W         = 13,
   parameter int               PIX_W          = 16,
   parameter logic [PIX_W-1:0] DEFAULT_COLOUR = '0
) (
   input  logic              clk100,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [PIX_W-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [PIX_W-1:0]  rdata
);

   // Power-up contents come from the bitstream; reset never clears the array.
   logic [PIX_W-1:0] mem [DEPTH] = '{default: DEFAULT_COLOUR};

   always_ff @(posedge clk100) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/frame_writer.sv
// Double-buffered frame store: producer fills the back bank, display reads the
// front bank, and the banks swap only when the display restarts at pixel 0.
module frame_writer
   import frame_pkg::*;
#(
   parameter int               WIDTH          = 96,
   parameter int               HEIGHT         = 64,
   parameter int               PIX_W          = 16,
   parameter logic [PIX_W-1:0] DEFAULT_COLOUR = 16'h0000
) (
   input  logic             clk100,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_sof,
   input  logic [IDX_W-1:0] pixel_index,
   output logic [PIX_W-1:0] oled_data,
   output logic             frame_done,
   output logic             err
);

   localparam int                DEPTH     = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic              front;
   logic [ADDR_W-1:0] waddr;

   logic              accept;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;

   logic              rd_clear;
   logic              rd_front;
   logic              rd_in_range;
   logic [PIX_W-1:0]  rdata0;
   logic [PIX_W-1:0]  rdata1;

   assign s_ready = (state != HOLD);
   assign accept  = s_valid && s_ready;
   assign wr_en   = accept && (s_sof || (state == WRITE));
   assign wr_addr = s_sof ? '0 : waddr;

   always_ff @(posedge clk100) begin
      if (reset) begin
         state      <= IDLE;
         front      <= 1'b0;
         waddr      <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && s_sof) begin
                  waddr <= ADDR_W'(1);
                  state <= WRITE;
               end
            end
            WRITE: begin
               // A fresh start-of-frame restarts the fill even on the last pixel.
               if (accept) begin
                  if (s_sof) begin
                     waddr <= ADDR_W'(1);
                     err   <= 1'b1;
                  end else if (waddr == LAST_ADDR) begin
                     waddr <= '0;
                     state <= HOLD;
                  end else begin
                     waddr <= waddr + ADDR_W'(1);
                  end
               end
            end
            HOLD: begin
               if (pixel_index == '0) begin
                  front      <= ~front;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bank select and range flag travel alongside the RAM read, so a read issued
   // on the swap edge still returns the old front bank.
   always_ff @(posedge clk100) begin
      if (reset) begin
         rd_clear    <= 1'b1;
         rd_front    <= 1'b0;
         rd_in_range <= 1'b0;
      end else begin
         rd_clear    <= 1'b0;
         rd_front    <= front;
         rd_in_range <= (pixel_index < IDX_W'(DEPTH));
      end
   end

   assign oled_data = rd_clear     ? '0 :
                      !rd_in_range ? DEFAULT_COLOUR :
                      rd_front     ? rdata1 : rdata0;

   frame_bank_ram #(
      .DEPTH          (DEPTH),
      .ADDR_W         (ADDR_W),
      .PIX_W          (PIX_W),
      .DEFAULT_COLOUR (DEFAULT_COLOUR)
   ) u_bank0 (
      .clk100 (clk100),
      .we     (wr_en && front),
      .waddr  (wr_addr),
      .wdata  (s_data),
      .raddr  (pixel_index[ADDR_W-1:0]),
      .rdata  (rdata0)
   );

   frame_bank_ram #(
      .DEPTH          (DEPTH),
      .ADDR_W         (ADDR_W),
      .PIX_W          (PIX_W),
      .DEFAULT_COLOUR (DEFAULT_COLOUR)
   ) u_bank1 (
      .clk100 (clk100),
      .we     (wr_en && !front),
      .waddr  (wr_addr),
      .wdata  (s_data),
      .raddr  (pixel_index[ADDR_W-1:0]),
      .rdata  (rdata1)
   );

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: fills, swaps, aborts, drops and resets frames.
module tb_frame_writer;

   logic        clk100 = 1'b0;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        s_sof;
   logic [13:0] pixel_index;
   logic [15:0] oled_data;
   logic        frame_done;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [13:0] idx;
      logic [15:0] exp;
   } rd_vec_t;

   rd_vec_t abort_reads [6];
   rd_vec_t final_reads [8];
   rd_vec_t reset_reads [5];

   always #5 clk100 = ~clk100;

   frame_writer dut (
      .clk100      (clk100),
      .reset       (reset),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_sof       (s_sof),
      .pixel_index (pixel_index),
      .oled_data   (oled_data),
      .frame_done  (frame_done),
      .err         (err)
   );

   task automatic step();
      @(posedge clk100);
      #1;
   endtask

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pat(input int mode, input int i);
      case (mode)
         0:       return 16'(i);
         1:       return 16'hA000 + 16'(i);
         2:       return 16'h2000 + 16'(i);
         3:       return 16'hFFFF - 16'(i);
         4:       return 16'h5555;
         default: return 16'hBEEF;
      endcase
   endfunction

   // Streams count beats of pattern mode starting at pixel first; s_sof on beat 0 if asked.
   task automatic apply_stimulus(input int mode, input int first, input int count, input bit sof_first);
      int stalls = 0;
      for (int k = 0; k < count; k++) begin
         s_valid = 1'b1;
         s_data  = pat(mode, first + k);
         s_sof   = sof_first && (k == 0);
         if (!s_ready) stalls++;
         step();
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      check_output($sformatf("stream_ready_m%0d", mode), 16'(stalls), 16'd0);
   endtask

   task automatic run_reads(input string name, input rd_vec_t v);
      pixel_index = v.idx;
      step();
      check_output($sformatf("%s_%0d", name, v.idx), oled_data, v.exp);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bad;

      abort_reads[0] = '{14'd0,    16'hF800};
      abort_reads[1] = '{14'd1,    16'h2001};
      abort_reads[2] = '{14'd150,  16'h2096};
      abort_reads[3] = '{14'd199,  16'h20C7};
      abort_reads[4] = '{14'd200,  16'h20C8};
      abort_reads[5] = '{14'd6143, 16'h37FF};

      final_reads[0] = '{14'd0,     16'hFFFF};
      final_reads[1] = '{14'd9,     16'hFFF6};
      final_reads[2] = '{14'd10,    16'hFFF5};
      final_reads[3] = '{14'd5000,  16'hEC77};
      final_reads[4] = '{14'd6143,  16'hE800};
      final_reads[5] = '{14'd6144,  16'h0000};
      final_reads[6] = '{14'd8191,  16'h0000};
      final_reads[7] = '{14'd16383, 16'h0000};

      reset_reads[0] = '{14'd0,    16'h5555};
      reset_reads[1] = '{14'd2999, 16'h5555};
      reset_reads[2] = '{14'd3000, 16'h2BB8};
      reset_reads[3] = '{14'd6143, 16'h37FF};
      reset_reads[4] = '{14'd6144, 16'h0000};

      reset       = 1'b1;
      s_valid     = 1'b0;
      s_data      = '0;
      s_sof       = 1'b0;
      pixel_index = '0;
      step();
      step();
      check_output("rst_oled", oled_data, 16'h0000);
      check_output("rst_ready", 16'(s_ready), 16'd1);
      check_output("rst_done", 16'(frame_done), 16'd0);
      check_output("rst_err", 16'(err), 16'd0);
      reset = 1'b0;

      // Power-up sweep of the front bank.
      bad = 0;
      for (int p = 0; p < 6144; p++) begin
         pixel_index = 14'(p);
         step();
         if (oled_data !== 16'h0000 || frame_done !== 1'b0 || err !== 1'b0 || s_ready !== 1'b1) bad++;
      end
      check_output("powerup_sweep_bad", 16'(bad), 16'd0);

      // Full frame of s_data = index, then a long HOLD before the display wraps.
      pixel_index = 14'd100;
      apply_stimulus(0, 0, 6144, 1'b1);
      check_output("hold_ready", 16'(s_ready), 16'd0);
      check_output("hold_done", 16'(frame_done), 16'd0);
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (s_ready !== 1'b0 || frame_done !== 1'b0 || oled_data !== 16'h0000) bad++;
      end
      check_output("hold_wait_bad", 16'(bad), 16'd0);
      pixel_index = 14'd0;
      step();
      check_output("swap1_done", 16'(frame_done), 16'd1);
      check_output("swap1_oldfront", oled_data, 16'h0000);
      pixel_index = 14'd5;
      step();
      check_output("swap1_done_once", 16'(frame_done), 16'd0);
      check_output("swap1_ready", 16'(s_ready), 16'd1);
      check_output("read_5", oled_data, 16'h0005);
      pixel_index = 14'd6143;
      step();
      check_output("read_6143", oled_data, 16'h17FF);

      // Abort after 200 beats with a new start-of-frame carrying F800.
      pixel_index = 14'd100;
      apply_stimulus(1, 0, 200, 1'b1);
      check_output("pre_abort_err", 16'(err), 16'd0);
      s_valid = 1'b1;
      s_sof   = 1'b1;
      s_data  = 16'hF800;
      step();
      s_valid = 1'b0;
      s_sof   = 1'b0;
      check_output("abort_err", 16'(err), 16'd1);
      apply_stimulus(2, 1, 1, 1'b0);
      check_output("abort_err_once", 16'(err), 16'd0);
      apply_stimulus(2, 2, 6142, 1'b0);
      check_output("abort_hold_ready", 16'(s_ready), 16'd0);
      pixel_index = 14'd0;
      step();
      check_output("swap2_done", 16'(frame_done), 16'd1);
      check_output("swap2_oldfront", oled_data, 16'h0000);
      for (int v = 0; v < 6; v++) run_reads("abort_read", abort_reads[v]);

      // Beats without s_sof in IDLE are dropped.
      pixel_index = 14'd100;
      apply_stimulus(5, 0, 10, 1'b0);
      check_output("drop_err", 16'(err), 16'd0);
      check_output("drop_done", 16'(frame_done), 16'd0);
      check_output("drop_ready", 16'(s_ready), 16'd1);
      apply_stimulus(3, 0, 6144, 1'b1);
      pixel_index = 14'd0;
      step();
      check_output("swap3_done", 16'(frame_done), 16'd1);
      check_output("swap3_oldfront", oled_data, 16'hF800);
      for (int v = 0; v < 8; v++) run_reads("final_read", final_reads[v]);

      // Reset in the middle of a frame: no swap, front back to bank 0.
      pixel_index = 14'd100;
      apply_stimulus(4, 0, 3000, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_output("midrst_oled", oled_data, 16'h0000);
      check_output("midrst_done", 16'(frame_done), 16'd0);
      check_output("midrst_err", 16'(err), 16'd0);
      check_output("midrst_ready", 16'(s_ready), 16'd1);
      pixel_index = 14'd0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (frame_done !== 1'b0) bad++;
      end
      check_output("midrst_noswap", 16'(bad), 16'd0);
      for (int v = 0; v < 5; v++) run_reads("reset_read", reset_reads[v]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
